// File: rtl/commit_trace_buffer_pkg.sv
// ============================================================================
// Module   : commit_trace_buffer_pkg
// Purpose  : Shared constants and helpers for the commit trace buffer:
//            event kind codes, trace entry field widths, the packed entry
//            width and the store byte-merge helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package commit_trace_buffer_pkg;

  // Event kind codes carried in the top bit of every trace entry.
  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  // Entry field widths; entry layout is {kind, pc, addr, data, stamp}.
  localparam int KIND_W = 1;
  localparam int PC_W   = 32;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DROP_W = 16;

  function automatic int entry_w(input int cw);
    return KIND_W + PC_W + ADDR_W + DATA_W + cw;
  endfunction

  // Store data replaces the enabled byte lanes of the current memory word.
  function automatic logic [31:0] merge_word(input logic [31:0] wdata,
                                             input logic [31:0] rdata,
                                             input logic [3:0]  byteen);
    logic [31:0] merged;
    merged = rdata;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/commit_trace_buffer_fifo.sv
// ============================================================================
// Module   : trace_fifo
// Purpose  : DEPTH x WIDTH entry store with two push ports and one pop port.
//            Port 0 is written ahead of port 1, so with both active port 0
//            lands in the older slot. The caller guarantees it never pushes
//            more entries than there is free space.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            push0_en/push0_data - first (older) push port
//            push1_en/push1_data - second push port
//            pop_en              - remove head entry (ignored when empty)
//            head_data           - current head entry
//            empty, full         - status flags
//            occupancy           - number of stored entries (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_fifo
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 129,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push0_en,
  input  logic [WIDTH-1:0] push0_data,
  input  logic             push1_en,
  input  logic [WIDTH-1:0] push1_data,
  input  logic             pop_en,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    slot0;
  logic [AW-1:0]    slot1;
  logic             do_pop;

  // Port 1 goes directly behind port 0 when both push, else into the tail.
  assign slot0 = wr_ptr[AW-1:0];
  assign slot1 = wr_ptr[AW-1:0] + AW'(push0_en);

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign occupancy = wr_ptr - rd_ptr;
  assign head_data = mem[rd_ptr[AW-1:0]];
  assign do_pop    = pop_en && !empty;

  always_ff @(posedge clk) begin
    if (push0_en) mem[slot0] <= push0_data;
    if (push1_en) mem[slot1] <= push1_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push0_en) + (AW+1)'(push1_en);
      rd_ptr <= rd_ptr + (AW+1)'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/commit_trace_buffer.sv
// ============================================================================
// Module   : commit_trace_buffer
// Purpose  : Turns the core's W-stage GRF writes and M-stage stores into a
//            single stamped event stream with valid/ready backpressure.
//            Same-cycle commits queue GRF first, then MEM. Events that do
//            not fit are dropped and counted (sticky overflow, saturating
//            16-bit drop counter).
// Ports    : clk, reset                      - clock, sync active-high reset
//            w_grf_we/addr/wdata, w_inst_addr - GRF commit observation
//            m_data_addr/wdata/byteen/rdata,
//            m_inst_addr                     - store commit observation
//            evt_valid/evt_ready             - output handshake
//            evt_kind/pc/addr/data/stamp     - head event fields
//            overflow, drop_cnt              - loss accounting
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_grf_we,
  input  logic [4:0]        w_grf_addr,
  input  logic [31:0]       w_grf_wdata,
  input  logic [31:0]       w_inst_addr,
  input  logic [31:0]       m_data_addr,
  input  logic [31:0]       m_data_wdata,
  input  logic [3:0]        m_data_byteen,
  input  logic [31:0]       m_data_rdata,
  input  logic [31:0]       m_inst_addr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              evt_kind,
  output logic [31:0]       evt_pc,
  output logic [31:0]       evt_addr,
  output logic [31:0]       evt_data,
  output logic [CW-1:0]     evt_stamp,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = entry_w(CW);

  logic [CW-1:0]      cycle_cnt;
  logic               grf_evt;
  logic               mem_evt;
  logic               grf_push;
  logic               mem_push;
  logic [ENTRY_W-1:0] grf_entry;
  logic [ENTRY_W-1:0] mem_entry;
  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic               fifo_full;
  logic [AW:0]        occupancy;
  logic [AW:0]        free_slots;
  logic [1:0]         drop_inc;
  logic [DROP_W:0]    drop_sum;

  assign grf_evt = w_grf_we && (w_grf_addr != 5'd0);
  assign mem_evt = |m_data_byteen;

  assign grf_entry = {KIND_GRF, w_inst_addr, {27'b0, w_grf_addr},
                      w_grf_wdata, cycle_cnt};
  assign mem_entry = {KIND_MEM, m_inst_addr, m_data_addr & 32'hFFFF_FFFC,
                      merge_word(m_data_wdata, m_data_rdata, m_data_byteen),
                      cycle_cnt};

  // Space is judged on start-of-cycle occupancy; a pop in this same cycle
  // does not make room. MEM needs a second slot only when GRF also fires.
  assign free_slots = (AW+1)'(DEPTH) - occupancy;
  assign grf_push   = grf_evt && !fifo_full;
  assign mem_push   = mem_evt && (grf_evt ? (free_slots >= (AW+1)'(2))
                                          : !fifo_full);

  // GRF always takes port 0 so it sits ahead of a same-cycle MEM event;
  // a lone MEM event also uses port 0.
  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push0_en   (grf_push || (mem_push && !grf_push)),
    .push0_data (grf_push ? grf_entry : mem_entry),
    .push1_en   (grf_push && mem_push),
    .push1_data (mem_entry),
    .pop_en     (evt_ready),
    .head_data  (head),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .occupancy  (occupancy)
  );

  // Fields read zero whenever nothing is queued, which covers the
  // post-reset state without exposing stale storage.
  assign evt_valid = !fifo_empty;
  always_comb begin
    {evt_kind, evt_pc, evt_addr, evt_data, evt_stamp} = '0;
    if (!fifo_empty) begin
      {evt_kind, evt_pc, evt_addr, evt_data, evt_stamp} = head;
    end
  end

  assign drop_inc = {1'b0, grf_evt && !grf_push} + {1'b0, mem_evt && !mem_push};
  assign drop_sum = {1'b0, drop_cnt} + {{(DROP_W-1){1'b0}}, drop_inc};

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (drop_inc != 2'd0) overflow <= 1'b1;
      drop_cnt <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end
  end

endmodule

`default_nettype wire
